uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: walks each frame through start/data/parity/stop bit
// phases, drives the external sampler and deserializer, and reports frame status.
module uart_rx_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       sampled_bit,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       busy,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err,
    output logic       strt_glitch
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [3:0] LastDataBit = 4'(DATA_W);

    state_e     state_q, state_d;
    logic [5:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic [5:0] pre_q, pre_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       acc_q, acc_d;
    logic       perr_seen_q, perr_seen_d;
    logic       dv_d, pe_d, se_d, sg_d;
    logic       bit_end;
    logic       start_frame;
    logic [5:0] pre_in;

    // Unsupported oversampling ratios fall back to 8.
    always_comb begin
        pre_in = 6'd8;
        case (Prescale)
            6'd8, 6'd16, 6'd32: pre_in = Prescale;
            default:            pre_in = 6'd8;
        endcase
    end

    assign bit_end = (edge_q == pre_q - 6'd1);

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        bit_d       = bit_q;
        pre_d       = pre_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        acc_d       = acc_q;
        perr_seen_d = perr_seen_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;
        sg_d        = 1'b0;
        start_frame = 1'b0;

        if (state_q != StIdle) begin
            if (bit_end) begin
                edge_d = 6'd0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + 6'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (!RX_IN) start_frame = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    if (sampled_bit) begin
                        sg_d    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    acc_d = acc_q ^ sampled_bit;
                    if (bit_q == LastDataBit) state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) begin
                    if (sampled_bit != (acc_q ^ par_typ_q)) begin
                        pe_d        = 1'b1;
                        perr_seen_d = 1'b1;
                    end
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    se_d = ~sampled_bit;
                    dv_d = sampled_bit & ~perr_seen_q;
                    // A low line on the final stop edge is already the next start bit.
                    if (!RX_IN) start_frame = 1'b1;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            edge_d = 6'd0;
            bit_d  = 4'd0;
        end

        if (start_frame) begin
            state_d     = StStart;
            edge_d      = 6'd0;
            bit_d       = 4'd0;
            pre_d       = pre_in;
            par_en_d    = PAR_EN;
            par_typ_d   = PAR_TYP;
            acc_d       = 1'b0;
            perr_seen_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            edge_q      <= 6'd0;
            bit_q       <= 4'd0;
            pre_q       <= 6'd8;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            acc_q       <= 1'b0;
            perr_seen_q <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            pre_q       <= pre_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            acc_q       <= acc_d;
            perr_seen_q <= perr_seen_d;
            data_valid  <= dv_d;
            par_err     <= pe_d;
            stp_err     <= se_d;
            strt_glitch <= sg_d;
        end
    end

    assign dat_samp_en = (state_q != StIdle);
    assign busy        = (state_q != StIdle);
    assign deser_en    = (state_q == StData) && bit_end;
    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level model checked every cycle, plus directed
// frame scenarios with hand-computed pulse counts and timings.
module tb_uart_rx_ctrl;

    localparam int DATA_W = 8;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic       deser_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;

    uart_rx_ctrl #(.DATA_W(DATA_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .busy        (busy),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    // Model: a frame is a run of k = 0 .. len-1 cycles; bit = k / P, edge = k % P.
    int m_k, m_p, m_len, m_e, m_b;
    bit m_on, m_pen, m_ptyp, m_acc, m_perr;
    bit m_dv, m_pe, m_se, m_sg;
    bit m_exit;

    function automatic int legal_p(input logic [5:0] v);
        return (v == 6'd8 || v == 6'd16 || v == 6'd32) ? int'(v) : 8;
    endfunction

    function automatic void m_start();
        m_on   = 1'b1;
        m_k    = 0;
        m_p    = legal_p(Prescale);
        m_pen  = PAR_EN;
        m_ptyp = PAR_TYP;
        m_len  = (2 + DATA_W + int'(m_pen)) * m_p;
        m_acc  = 1'b0;
        m_perr = 1'b0;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_on = 0; m_k = 0; m_p = 8; m_len = 0; m_pen = 0; m_ptyp = 0;
            m_acc = 0; m_perr = 0; m_dv = 0; m_pe = 0; m_se = 0; m_sg = 0;
            if (CLK) cyc++;
        end else begin
            cyc++;
            m_dv = 0; m_pe = 0; m_se = 0; m_sg = 0;
            if (!m_on) begin
                if (!RX_IN) m_start();
            end else begin
                m_e    = m_k % m_p;
                m_b    = m_k / m_p;
                m_exit = 1'b0;
                if (m_e == m_p - 1) begin
                    if (m_b == 0) begin
                        if (sampled_bit) begin
                            m_sg = 1; m_on = 0; m_k = 0; m_exit = 1;
                        end
                    end else if (m_b <= DATA_W) begin
                        m_acc ^= sampled_bit;
                    end else if (m_pen && m_b == DATA_W + 1) begin
                        if (sampled_bit != (m_acc ^ m_ptyp)) begin
                            m_pe = 1; m_perr = 1;
                        end
                    end else if (m_b == m_len / m_p - 1) begin
                        m_se   = !sampled_bit;
                        m_dv   = sampled_bit && !m_perr;
                        m_exit = 1;
                        if (!RX_IN) m_start();
                        else begin m_on = 0; m_k = 0; end
                    end
                end
                if (!m_exit) m_k++;
            end
        end
    end

    // Per-cycle comparison plus pulse bookkeeping for the directed checks.
    int c_e, c_b;
    logic [16:0] act_v, exp_v;
    int dv_n, pe_n, se_n, sg_n, des_n, dv_last, dv_prev, sg_last;

    always @(negedge CLK) begin
        c_e = m_k % m_p;
        c_b = m_k / m_p;
        exp_v = {m_on, (m_on && c_b >= 1 && c_b <= DATA_W && c_e == m_p - 1), 6'(c_e), 4'(c_b),
                 m_on, m_dv, m_pe, m_se, m_sg};
        act_v = {dat_samp_en, deser_en, edge_cnt, bit_cnt, busy,
                 data_valid, par_err, stp_err, strt_glitch};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
        end
        if (data_valid === 1'b1) begin dv_n++; dv_prev = dv_last; dv_last = cyc; end
        if (par_err === 1'b1) pe_n++;
        if (stp_err === 1'b1) se_n++;
        if (strt_glitch === 1'b1) begin sg_n++; sg_last = cyc; end
        if (deser_en === 1'b1) des_n++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clr();
        dv_n = 0; pe_n = 0; se_n = 0; sg_n = 0; des_n = 0;
        dv_last = 0; dv_prev = 0; sg_last = 0;
    endtask

    // Drives one frame; RX_IN glitches mid-bit, config is scrambled after latching
    // and restored for the final stop cycle (where a back-to-back start is latched).
    task automatic send_frame(input logic [5:0] pv, input logic pe, input logic pt,
                              input logic [7:0] data, input logic pbit, input logic sbit,
                              input bit started, input bit b2b);
        int p, nb;
        logic v;
        p  = legal_p(pv);
        nb = 2 + DATA_W + int'(pe);
        if (!started) begin
            Prescale = pv; PAR_EN = pe; PAR_TYP = pt;
            RX_IN = 1'b0; sampled_bit = 1'b0;
            start_cyc = cyc + 1;
            tick();
        end else begin
            start_cyc = cyc;
        end
        Prescale = pv ^ 6'h18; PAR_EN = ~pe; PAR_TYP = ~pt;
        for (int i = 0; i < nb; i++) begin
            if (i == 0) v = 1'b0;
            else if (i <= DATA_W) v = data[i-1];
            else if (pe && i == DATA_W + 1) v = pbit;
            else v = sbit;
            sampled_bit = v;
            for (int c = 0; c < p; c++) begin
                if (i == nb - 1 && c == p - 1) begin
                    RX_IN = !b2b; Prescale = pv; PAR_EN = pe; PAR_TYP = pt;
                end else begin
                    RX_IN = (c == p / 2) ? !v : v;
                end
                tick();
            end
        end
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; sampled_bit = 1'b1;
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        clr();
        #1;
        chk("reset_outputs", int'({dat_samp_en, deser_en, edge_cnt, bit_cnt, busy,
                                   data_valid, par_err, stp_err, strt_glitch}), 0);
        tick(); tick();
        RST = 1'b1;
        idle(3);

        // P=8 even parity, 0xA5 (four ones) with parity 0: clean frame.
        clr();
        send_frame(6'd8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 0);
        idle(3);
        chk("good_deser_cnt", des_n, 8);
        chk("good_dv_cnt", dv_n, 1);
        chk("good_dv_latency", dv_last - start_cyc, 88);
        chk("good_perr_cnt", pe_n, 0);
        chk("good_serr_cnt", se_n, 0);

        // Same frame, wrong parity bit.
        clr();
        send_frame(6'd8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 0, 0);
        idle(3);
        chk("par_perr_cnt", pe_n, 1);
        chk("par_dv_cnt", dv_n, 0);

        // P=16 no parity, 0x3C with a bad stop bit.
        clr();
        send_frame(6'd16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 0);
        idle(3);
        chk("stop_serr_cnt", se_n, 1);
        chk("stop_dv_cnt", dv_n, 0);
        chk("stop_busy_after", int'(busy), 0);

        // Start-bit glitch: line low for 3 cycles, sampler votes high.
        clr();
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        RX_IN = 1'b0; sampled_bit = 1'b1;
        start_cyc = cyc + 1;
        repeat (3) tick();
        RX_IN = 1'b1;
        repeat (6) tick();
        idle(3);
        chk("glitch_cnt", sg_n, 1);
        chk("glitch_time", sg_last - start_cyc, 8);
        chk("glitch_deser_cnt", des_n, 0);
        chk("glitch_busy_after", int'(busy), 0);

        // Back-to-back P=8 frames with no idle gap.
        clr();
        send_frame(6'd8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 0, 1);
        send_frame(6'd8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1, 0);
        idle(3);
        chk("b2b_dv_cnt", dv_n, 2);
        chk("b2b_dv_gap", dv_last - dv_prev, 80);
        chk("b2b_deser_cnt", des_n, 16);

        // Odd parity, P=32, and an unsupported prescale treated as 8.
        clr();
        send_frame(6'd8, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 0, 0);
        idle(3);
        send_frame(6'd32, 1'b1, 1'b0, 8'h5B, 1'b1, 1'b1, 0, 0);
        idle(3);
        send_frame(6'd12, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 0, 0);
        idle(3);
        chk("misc_dv_cnt", dv_n, 3);
        chk("misc_err_cnt", pe_n + se_n + sg_n, 0);
        chk("illegal_p_latency", dv_last - start_cyc, 80);

        // Reset in the middle of data bit 4.
        clr();
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        RX_IN = 1'b0; sampled_bit = 1'b0;
        tick();
        repeat (34) tick();
        chk("rst_bit_cnt_before", int'(bit_cnt), 4);
        RST = 1'b0;
        #1;
        chk("rst_midframe_outputs", int'({dat_samp_en, deser_en, edge_cnt, bit_cnt, busy,
                                          data_valid, par_err, stp_err, strt_glitch}), 0);
        RX_IN = 1'b1; sampled_bit = 1'b1;
        tick(); tick();
        RST = 1'b1;
        idle(20);
        chk("rst_no_pulses", dv_n + pe_n + se_n + sg_n, 0);
        clr();
        send_frame(6'd8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0, 0);
        idle(3);
        chk("rst_next_dv_cnt", dv_n, 1);
        chk("rst_next_latency", dv_last - start_cyc, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
